// File: rtl/booth_r8_digit_decoder.sv
// Serial radix-8 Booth digit decoder: accumulates one signed digit per handshake, LSB group
// first, and presents the reconstructed WIDTH-bit operand. Define BOOTH_DEC_CHECK_EN to build the error checks.
module booth_r8_digit_decoder #(
    parameter int WIDTH     = 16,
    parameter int GROUP_CNT = (WIDTH + 3) / 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_s,
    input  logic             in_d,
    input  logic             in_t,
    input  logic             in_q,
    input  logic             in_n,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_value,
    output logic             out_err
);

    localparam int ACC_W = 3 * GROUP_CNT + 1;
    localparam int IDX_W = (GROUP_CNT > 1) ? $clog2(GROUP_CNT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(GROUP_CNT - 1);

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_DONE  = 1'b1;

    logic [0:0]              state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [WIDTH-1:0]        out_value_q, out_value_d;

    logic [2:0]              mag;
    logic signed [ACC_W-1:0] mag_ext;
    logic signed [ACC_W-1:0] digit_val;
    logic [IDX_W+1:0]        shamt;
    logic signed [ACC_W-1:0] acc_next;
    logic                    last_grp;

    // Malformed one-hot codes decode by priority q>t>d>s.
    always_comb begin
        mag = 3'd0;
        if (in_q)      mag = 3'd4;
        else if (in_t) mag = 3'd3;
        else if (in_d) mag = 3'd2;
        else if (in_s) mag = 3'd1;
    end

    always_comb begin
        mag_ext   = {{(ACC_W-3){1'b0}}, mag};
        digit_val = in_n ? -mag_ext : mag_ext;
        shamt     = {1'b0, idx_q, 1'b0} + {2'b00, idx_q};
        acc_next  = acc_q + (digit_val <<< shamt);
        last_grp  = (idx_q == LAST_IDX);
    end

    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_DONE);
    assign out_value = out_value_q;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        out_value_d = out_value_q;
        case (state_q)
            ST_ACCUM: begin
                if (flush) begin
                    acc_d = '0;
                    idx_d = '0;
                end else if (in_valid) begin
                    if (last_grp) begin
                        state_d     = ST_DONE;
                        out_value_d = acc_next[WIDTH-1:0];
                        acc_d       = '0;
                        idx_d       = '0;
                    end else begin
                        acc_d = acc_next;
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_ACCUM;
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACCUM;
            acc_q       <= '0;
            idx_q       <= '0;
            out_value_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            out_value_q <= out_value_d;
        end
    end

`ifdef BOOTH_DEC_CHECK_EN
    logic err_q, err_d;
    logic out_err_q, out_err_d;
    logic dig_illegal, range_err;

    always_comb begin
        dig_illegal = (in_q & (in_t | in_d | in_s)) | (in_t & (in_d | in_s)) | (in_d & in_s);
        // Result must land in [0, 2^WIDTH): negative, or any bit at/above WIDTH set.
        range_err   = acc_next[ACC_W-1] | (|acc_next[ACC_W-2:WIDTH]);
        err_d       = err_q;
        out_err_d   = out_err_q;
        if (state_q == ST_ACCUM) begin
            if (flush) begin
                err_d = 1'b0;
            end else if (in_valid) begin
                if (last_grp) begin
                    out_err_d = err_q | dig_illegal | range_err;
                    err_d     = 1'b0;
                end else begin
                    err_d = err_q | dig_illegal;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q     <= 1'b0;
            out_err_q <= 1'b0;
        end else begin
            err_q     <= err_d;
            out_err_q <= out_err_d;
        end
    end

    assign out_err = out_err_q;
`else
    assign out_err = 1'b0;
`endif

endmodule
